// File: rtl/present_pkg.sv
// PRESENT-80 shared constants and sequencer state encoding.
// Imported by the round datapath, key schedule and encrypt_seq.
package present_pkg;

  localparam int BLOCK_W    = 64;
  localparam int KEY_W      = 80;
  localparam int RC_W       = 5;
  localparam int NUM_ROUNDS = 31;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_t;

endpackage

// File: rtl/key_schedule.sv
// PRESENT-80 key register update.
// Computes the next round key from the current key and the round counter.
module key_schedule
  import present_pkg::*;
(
  input  logic [KEY_W-1:0] k,
  input  logic [RC_W-1:0]  rc,
  output logic [KEY_W-1:0] nk
);

  logic [KEY_W-1:0] t;
  logic [3:0]       s;

  assign t = {k[18:0], k[79:19]};

  sbox u_sbox (
    .x (t[79:76]),
    .y (s)
  );

  assign nk = {s, t[75:20], t[19:15] ^ rc, t[14:0]};

endmodule

// File: rtl/round.sv
// Single-cycle PRESENT round.
// Performs key add, sBoxLayer and pLayer.
module round
  import present_pkg::*;
(
  input  logic [BLOCK_W-1:0] st,
  input  logic [KEY_W-1:0]   key,
  output logic [BLOCK_W-1:0] nxt
);

  logic [BLOCK_W-1:0] ak;
  logic [BLOCK_W-1:0] sb;

  assign ak = st ^ key[KEY_W-1:KEY_W-BLOCK_W];

  for (genvar i = 0; i < BLOCK_W / 4; i++) begin : g_sb
    sbox u_sbox (
      .x (ak[4*i +: 4]),
      .y (sb[4*i +: 4])
    );
  end

  // bit i moves to 16*i mod 63; bit 63 stays put
  always_comb begin
    nxt = '0;
    for (int i = 0; i < BLOCK_W; i++) begin
      if (i == BLOCK_W - 1)
        nxt[i] = sb[i];
      else
        nxt[(i * 16) % 63] = sb[i];
    end
  end

endmodule

// File: rtl/sbox.sv
// PRESENT 4-bit S-box.
// Nibble i of the table constant is S(i).
module sbox (
  input  logic [3:0] x,
  output logic [3:0] y
);

  localparam logic [63:0] LUT = 64'h21748FE3DA09B65C;

  assign y = LUT[{x, 2'b00} +: 4];

endmodule

// File: rtl/encrypt_seq.sv
// Iterative PRESENT-80 encryption sequencer.
// Applies one round per cycle, then adds the final whitening key.
module encrypt_seq
  import present_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_x,
  input  logic [KEY_W-1:0]   in_k,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_r,
  output logic               busy
);

  fsm_t               fsm;
  fsm_t               fsm_nxt;
  logic [BLOCK_W-1:0] st;
  logic [KEY_W-1:0]   key;
  logic [RC_W-1:0]    rc;
  logic [BLOCK_W-1:0] st_nxt;
  logic [KEY_W-1:0]   key_nxt;
  logic               last;

  round u_round (
    .st  (st),
    .key (key),
    .nxt (st_nxt)
  );

  key_schedule u_ks (
    .k  (key),
    .rc (rc),
    .nk (key_nxt)
  );

  assign last = (rc == RC_W'(NUM_ROUNDS));

  always_comb begin
    fsm_nxt = fsm;
    unique case (fsm)
      IDLE:    if (in_valid)  fsm_nxt = RUN;
      RUN:     if (last)      fsm_nxt = DONE;
      DONE:    if (out_ready) fsm_nxt = IDLE;
      default:                fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm <= IDLE;
      st  <= '0;
      key <= '0;
      rc  <= '0;
    end else begin
      fsm <= fsm_nxt;
      unique case (fsm)
        IDLE: begin
          if (in_valid) begin
            st  <= in_x;
            key <= in_k;
            rc  <= RC_W'(1);
          end
        end
        RUN: begin
          st  <= st_nxt;
          key <= key_nxt;
          // saturate so the counter never wraps
          if (!last)
            rc <= rc + RC_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (fsm == IDLE);
  assign out_valid = (fsm == DONE);
  assign busy      = (fsm == RUN) || (fsm == DONE);
  assign out_r     = out_valid ? (st ^ key[KEY_W-1:KEY_W-BLOCK_W]) : '0;

endmodule

// File: tb/tb_encrypt_seq.sv
// Directed known-answer bench for encrypt_seq.
// Covers latency, back-to-back, backpressure and reset abort.
module tb_encrypt_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_x;
  logic [79:0] in_k;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_r;
  logic        busy;

  int nvec = 0;
  int nerr = 0;

  localparam logic [63:0] C1 = 64'h5579C1387B228445;
  localparam logic [63:0] C2 = 64'hE72C46C0F5945049;
  localparam logic [63:0] C3 = 64'hA112FFC72F68417B;
  localparam logic [63:0] C4 = 64'h3333DCD3213210D2;
  localparam logic [63:0] X1 = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [79:0] K1 = 80'hFFFFFFFFFFFFFFFFFFFF;

  always #5 clk = ~clk;

  encrypt_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_k      (in_k),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [79:0] got,
                     input logic [79:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"},  80'(in_ready),  80'd1);
    chk({tag, "_out_valid"}, 80'(out_valid), 80'd0);
    chk({tag, "_out_r"},     80'(out_r),     80'd0);
    chk({tag, "_busy"},      80'(busy),      80'd0);
  endtask

  // returns the time of the accept edge; in_valid stays high
  task automatic accept(input logic [63:0] x, input logic [79:0] k,
                        output time t);
    int n;
    n = 0;
    @(negedge clk);
    in_x     = x;
    in_k     = k;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 80'(in_ready), 80'd1);
    @(posedge clk);
    t = $time;
  endtask

  // counts negedges after accept until out_valid, first one is 1
  task automatic wait_out(input int start, output int lat);
    lat = start;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic kat(input string tag, input logic [63:0] x,
                     input logic [79:0] k, input logic [63:0] exp);
    time t;
    int  lat;
    accept(x, k, t);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_run_busy"},  80'(busy),     80'd1);
    chk({tag, "_run_ready"}, 80'(in_ready), 80'd0);
    wait_out(1, lat);
    chk({tag, "_latency"}, 80'(lat),   80'd32);
    chk({tag, "_out_r"},   80'(out_r), 80'(exp));
    if (out_ready) begin
      @(negedge clk);
      chk_idle({tag, "_after"});
    end
  endtask

  initial begin
    time t0;
    time t1;
    int  lat;
    bit  seen;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_x      = '0;
    in_k      = '0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_idle("post_reset");

    kat("kat1", 64'h0, 80'h0, C1);

    // backpressure on KAT 2
    out_ready = 1'b0;
    kat("kat2", 64'h0, K1, C2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_x     = {2{$urandom}};
      in_k     = {16'(i), $urandom, $urandom};
      chk("bp_out_valid", 80'(out_valid), 80'd1);
      chk("bp_out_r",     80'(out_r),     80'(C2));
      chk("bp_in_ready",  80'(in_ready),  80'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk_idle("bp_release");

    // KAT 3 then KAT 4 with in_valid held high
    accept(X1, 80'h0, t0);
    @(negedge clk);
    in_k = K1;
    wait_out(1, lat);
    chk("kat3_latency", 80'(lat),   80'd32);
    chk("kat3_out_r",   80'(out_r), 80'(C3));
    @(negedge clk);
    chk("b2b_in_ready", 80'(in_ready), 80'd1);
    @(posedge clk);
    t1 = $time;
    chk("b2b_interval", 80'((t1 - t0) / 10), 80'd33);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(1, lat);
    chk("kat4_latency", 80'(lat),   80'd32);
    chk("kat4_out_r",   80'(out_r), 80'(C4));
    @(negedge clk);
    chk_idle("kat4_after");

    // reset while rc is 15
    accept(64'h0, 80'h0, t0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (14) @(negedge clk);
    chk("abort_busy", 80'(busy), 80'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("abort");
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_valid", 80'(seen), 80'd0);

    kat("kat1_again", 64'h0, 80'h0, C1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/encrypt_seq.md
# encrypt_seq

Iterative PRESENT-80 encryption engine: a sequencer wrapped around the existing single-cycle `round` datapath. It accepts a 64-bit plaintext and an 80-bit key over a valid/ready handshake and applies `round` once per cycle for 31 cycles. The 80-bit key register advances through the PRESENT-80 key schedule in lockstep. The final whitening key is then added and the ciphertext is presented on an output valid/ready handshake. It sits between the messaging front end (block producer) and the ciphertext sink.

## Interface

- Parameters: none; all widths and the round count are fixed constants (see Structure).
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  plaintext/key pair offered.
- `in_ready`  output  1  engine can accept a block; high only in IDLE.
- `in_x`  input  64  plaintext block.
- `in_k`  input  80  cipher key.
- `out_valid`  output  1  ciphertext available; high only in DONE.
- `out_ready`  input  1  sink accepts ciphertext.
- `out_r`  output  64  ciphertext; forced to 0 whenever `out_valid`=0.
- `busy`  output  1  high in RUN or DONE.

## Operation

- Registers:
  - `st` is 64 bits.
  - `key` is 80 bits.
  - `rc` is the 5-bit round counter.
  - `fsm` holds one of IDLE, RUN, DONE.
- Reset: `fsm`=IDLE, `st`=0, `key`=0, `rc`=0.
- Reset outputs: `in_ready`=1, `out_valid`=0, `out_r`=0, `busy`=0.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: `st`<=`in_x`, `key`<=`in_k`, `rc`<=1, go to RUN.
  - Otherwise hold all registers.
- RUN, every cycle:
  - `st` <= `round(st, key)`.
  - `key` <= `next_key(key, rc)`.
  - `rc` <= `rc`+1.
  - When `rc`==31, go to DONE; `rc` never wraps.
- Key schedule `next_key(k, rc)`, in this order:
  1. Rotate left by 61 bits: t = {k[18:0], k[79:19]}.
  2. Replace t[79:76] with S(t[79:76]).
  3. Set t[19:15] ^= rc.
- Round key: `round` consumes the full 80-bit `key`; the key-addition stage uses `key[79:16]`.
- DONE:
  - `out_valid`=1 and `out_r` = `st` ^ `key[79:16]`, i.e. the final whitening with K32.
  - `st`, `key` and `rc` are held stable while `out_ready`=0.
  - On `out_ready`, go to IDLE.
- `in_ready` is 0 in RUN and DONE. A block offered then is not consumed, and its inputs are ignored.
- `in_x` and `in_k` are sampled only at the accept edge. Changes afterwards have no effect.
- Reset mid-RUN or mid-DONE aborts the block: no `out_valid` pulse; the next cycle is IDLE with reset values.
- `rst` has priority over all handshakes in the same cycle.

## Timing

- Accept edge E0 is the edge where `in_valid` & `in_ready` are both 1.
- RUN occupies the cycles after edges E0..E30, 31 cycles in total.
- `out_valid` first rises in the cycle after edge E31. That is 32 cycles after the accept cycle, with zero backpressure.
- The output handshake completes at the edge where `out_valid` & `out_ready` are both 1. `in_ready` rises in the following cycle.
- Minimum initiation interval is 33 cycles per block.
- `out_r` is combinational from registers only; there is no input-to-output combinational path.
- `in_ready`, `out_valid` and `busy` decode from `fsm` only.

## Structure

- Package `present_pkg`:
  - `BLOCK_W`=64, `KEY_W`=80, `RC_W`=5, `NUM_ROUNDS`=31.
  - FSM enum {IDLE, RUN, DONE}.
- Sub-module `key_schedule`: combinational `next_key`, with inputs k[79:0] and rc[4:0]. It reuses `sbox` for the nibble substitution.
- `encrypt_seq` instantiates `round` and `key_schedule`, plus the FSM and registers.

## Test plan

- KAT 1: `in_x`=0, `in_k`=0 -> `out_r`=5579C1387B228445, with `out_valid` first high exactly 32 cycles after accept.
- KAT 2: `in_x`=0, `in_k`=FFFFFFFFFFFFFFFFFFFF -> `out_r`=E72C46C0F5945049.
- KAT 3 and 4:
  - `in_x`=FFFFFFFFFFFFFFFF, `in_k`=0 -> A112FFC72F68417B.
  - Both inputs all-ones -> 3333DCD3213210D2.
  - Run back-to-back with `in_valid` held high; check second accept exactly 33 cycles after first.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE.
  - `out_r` stays at its value and `out_valid` stays 1.
  - `in_ready` stays 0; changing `in_x`/`in_k` during this time has no effect.
- Reset abort: assert `rst` for 1 cycle at RUN `rc`=15.
  - `out_valid` never rises.
  - Next cycle: IDLE, `in_ready`=1, `out_r`=0, `busy`=0.
  - A subsequent KAT 1 then passes.
